// File: rtl/key_event_queue_pkg.sv
// Shared definitions for the key event queue: register map, STATUS/CTRL bit
// positions and the layout of a queued entry.
package key_event_queue_pkg;

    typedef enum logic [3:0] {
        REG_ID     = 4'd0,
        REG_STATUS = 4'd1,
        REG_DATA   = 4'd2,
        REG_CTRL   = 4'd3,
        REG_TIME   = 4'd4
    } reg_addr_e;

    localparam logic [31:0] ID_VALUE = 32'd65;

    localparam int unsigned ST_COUNT_LSB = 0;
    localparam int unsigned ST_COUNT_W   = 9;
    localparam int unsigned ST_EMPTY_BIT = 9;
    localparam int unsigned ST_FULL_BIT  = 10;
    localparam int unsigned ST_OVF_BIT   = 11;

    localparam int unsigned CTRL_IRQ_EN_BIT  = 0;
    localparam int unsigned CTRL_OVF_CLR_BIT = 1;
    localparam int unsigned CTRL_FLUSH_BIT   = 2;

    localparam int unsigned ENTRY_W       = 32;
    localparam int unsigned ENTRY_KEY_LSB = 0;
    localparam int unsigned ENTRY_KEY_W   = 4;
    localparam int unsigned ENTRY_TS_LSB  = 16;
    localparam int unsigned ENTRY_TS_W    = 16;

    function automatic logic [ENTRY_W-1:0] make_entry(
        input logic [ENTRY_TS_W-1:0]  ts,
        input logic [ENTRY_KEY_W-1:0] keys
    );
        logic [ENTRY_W-1:0] e;
        e = '0;
        e[ENTRY_TS_LSB +: ENTRY_TS_W]   = ts;
        e[ENTRY_KEY_LSB +: ENTRY_KEY_W] = keys;
        return e;
    endfunction

endpackage

// File: rtl/key_event_queue_fifo.sv
// key_event_fifo: circular buffer with wrapping pointers, occupancy count and
// full/empty flags; flush has priority over push and pop.
module key_event_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_FULL);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a push into a full buffer is still taken.
    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    assign do_push = push_i & ~flush_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/key_event_queue.sv
// key_event_queue: timestamps debounced key presses into a FIFO and exposes it
// to the CPU over an Avalon-MM slave with a level interrupt.
module key_event_queue
    import key_event_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned TS_W     = 16
) (
    input  logic        csi_clk,
    input  logic        rsi_reset_n,
    input  logic        avs_s0_write,
    input  logic        avs_s0_read,
    input  logic [3:0]  avs_s0_address,
    input  logic [31:0] avs_s0_writedata,
    output logic [31:0] avs_s0_readdata,
    input  logic [3:0]  key_pulse,
    output logic        ins_irq
);

    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned CW   = $clog2(DEPTH) + 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);
    localparam logic [TS_W-1:0] TS_ONE  = TS_W'(1);

    logic [PS_W-1:0]    presc_q, presc_d;
    logic [TS_W-1:0]    ts_q, ts_d;
    logic               ovf_q, ovf_d;
    logic               irq_en_q, irq_en_d;
    logic               irq_q, irq_d;

    logic               push, pop, flush, ovf_clr, ovf_set, ctrl_wr, data_rd;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic [CW-1:0]      fifo_count;
    logic               fifo_empty, fifo_full;
    logic               unused_wdata;

    assign unused_wdata = ^avs_s0_writedata[31:3];

    assign data_rd = avs_s0_read  & (reg_addr_e'(avs_s0_address) == REG_DATA);
    assign ctrl_wr = avs_s0_write & (reg_addr_e'(avs_s0_address) == REG_CTRL);
    assign push    = |key_pulse;
    assign pop     = data_rd & ~fifo_empty;
    assign flush   = ctrl_wr & avs_s0_writedata[CTRL_FLUSH_BIT];
    assign ovf_clr = ctrl_wr & avs_s0_writedata[CTRL_OVF_CLR_BIT];
    // A flush discards the concurrent press outright, so it never counts as overflow.
    assign ovf_set = push & fifo_full & ~pop & ~flush;

    key_event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .CW    (CW)
    ) u_fifo (
        .clk_i   (csi_clk),
        .rst_ni  (rsi_reset_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (make_entry(ts_q, key_pulse)),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    always_comb begin
        presc_d  = presc_q + PS_ONE;
        ts_d     = ts_q;
        ovf_d    = ovf_q;
        irq_en_d = irq_en_q;
        if (presc_q == PS_LAST) begin
            presc_d = '0;
            ts_d    = ts_q + TS_ONE;
        end
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (ctrl_wr) irq_en_d = avs_s0_writedata[CTRL_IRQ_EN_BIT];
        irq_d = irq_en_q & ~fifo_empty;
    end

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            presc_q  <= '0;
            ts_q     <= '0;
            ovf_q    <= 1'b0;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            ts_q     <= ts_d;
            ovf_q    <= ovf_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign ins_irq = irq_q;

    always_comb begin
        avs_s0_readdata = '0;
        if (avs_s0_read) begin
            case (reg_addr_e'(avs_s0_address))
                REG_ID:     avs_s0_readdata = ID_VALUE;
                REG_STATUS: begin
                    avs_s0_readdata[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(fifo_count);
                    avs_s0_readdata[ST_EMPTY_BIT] = fifo_empty;
                    avs_s0_readdata[ST_FULL_BIT]  = fifo_full;
                    avs_s0_readdata[ST_OVF_BIT]   = ovf_q;
                end
                REG_DATA:   if (!fifo_empty) avs_s0_readdata = fifo_rdata;
                REG_CTRL:   avs_s0_readdata[CTRL_IRQ_EN_BIT] = irq_en_q;
                REG_TIME:   avs_s0_readdata[TS_W-1:0] = ts_q;
                default:    avs_s0_readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_key_event_queue.sv
// Scoreboard bench for key_event_queue: expected entries are queued as presses
// are driven and compared against DATA reads.
module tb_key_event_queue;

    localparam int unsigned DEPTH    = 16;
    localparam int unsigned PRESCALE = 4;

    logic        csi_clk = 1'b0;
    logic        rsi_reset_n = 1'b0;
    logic        avs_s0_write = 1'b0;
    logic        avs_s0_read = 1'b0;
    logic [3:0]  avs_s0_address = '0;
    logic [31:0] avs_s0_writedata = '0;
    logic [31:0] avs_s0_readdata;
    logic [3:0]  key_pulse = '0;
    logic        ins_irq;

    always #5 csi_clk = ~csi_clk;

    key_event_queue #(
        .DEPTH    (DEPTH),
        .PRESCALE (PRESCALE),
        .TS_W     (16)
    ) dut (
        .csi_clk          (csi_clk),
        .rsi_reset_n      (rsi_reset_n),
        .avs_s0_write     (avs_s0_write),
        .avs_s0_read      (avs_s0_read),
        .avs_s0_address   (avs_s0_address),
        .avs_s0_writedata (avs_s0_writedata),
        .avs_s0_readdata  (avs_s0_readdata),
        .key_pulse        (key_pulse),
        .ins_irq          (ins_irq)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned edges;
    logic [31:0] sb [$];
    logic        ovf_m    = 1'b0;
    logic        irq_en_m = 1'b0;

    always @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) edges <= 0;
        else              edges <= edges + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ts_m();
        return 16'(edges / PRESCALE);
    endfunction

    function automatic logic [31:0] status_m();
        logic [31:0] s;
        s = '0;
        s[8:0] = 9'(sb.size());
        s[9]   = (sb.size() == 0);
        s[10]  = (sb.size() == DEPTH);
        s[11]  = ovf_m;
        return s;
    endfunction

    // One bus cycle: drive at negedge, compare readdata against the model, update the model.
    task automatic bus_cycle(input string tag, input logic [3:0] keys, input logic rd,
                             input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rdata);
        logic [31:0] exp;
        logic        pop, flush, full_before, ovf_set;
        @(negedge csi_clk);
        key_pulse        = keys;
        avs_s0_read      = rd;
        avs_s0_write     = wr;
        avs_s0_address   = addr;
        avs_s0_writedata = wdata;
        #1;
        rdata = avs_s0_readdata;
        exp   = '0;
        if (rd) begin
            case (addr)
                4'd0:    exp = 32'd65;
                4'd1:    exp = status_m();
                4'd2:    exp = (sb.size() != 0) ? sb[0] : 32'h0;
                4'd3:    exp = {31'b0, irq_en_m};
                4'd4:    exp = {16'b0, ts_m()};
                default: exp = '0;
            endcase
        end
        check_eq(tag, rdata, exp);
        pop         = rd && (addr == 4'd2) && (sb.size() != 0);
        flush       = wr && (addr == 4'd3) && wdata[2];
        full_before = (sb.size() == DEPTH);
        ovf_set     = 1'b0;
        if (flush) begin
            sb.delete();
        end else begin
            if (pop) void'(sb.pop_front());
            if (keys != 4'b0) begin
                if (!full_before || pop) sb.push_back({ts_m(), 12'b0, keys});
                else ovf_set = 1'b1;
            end
        end
        if (wr && addr == 4'd3) begin
            irq_en_m = wdata[0];
            if (wdata[1]) ovf_m = 1'b0;
        end
        if (ovf_set) ovf_m = 1'b1;
        @(posedge csi_clk);
        #1;
        key_pulse    = '0;
        avs_s0_read  = 1'b0;
        avs_s0_write = 1'b0;
    endtask

    task automatic idle();
        logic [31:0] r;
        bus_cycle("idle", 4'b0, 1'b0, 1'b0, 4'd0, 32'h0, r);
    endtask

    task automatic pulse(input logic [3:0] keys);
        logic [31:0] r;
        bus_cycle("pulse", keys, 1'b0, 1'b0, 4'd0, 32'h0, r);
    endtask

    task automatic rd_reg(input logic [3:0] a, output logic [31:0] d);
        bus_cycle($sformatf("rd_a%0d", a), 4'b0, 1'b1, 1'b0, a, 32'h0, d);
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
        logic [31:0] r;
        bus_cycle($sformatf("wr_a%0d", a), 4'b0, 1'b0, 1'b1, a, d, r);
    endtask

    initial begin
        logic [31:0] r;

        repeat (3) @(posedge csi_clk);
        @(negedge csi_clk);
        rsi_reset_n = 1'b1;
        #1;
        check_eq("irq_reset", {31'b0, ins_irq}, 32'h0);
        check_eq("rdata_idle_reset", avs_s0_readdata, 32'h0);
        rd_reg(4'd0, r);
        check_eq("id", r, 32'd65);
        rd_reg(4'd1, r);
        check_eq("status_reset", r, 32'h200);

        for (int i = 0; i < 64 && edges < 3 * PRESCALE; i++) idle();
        rd_reg(4'd4, r);
        check_eq("time_3", r, 32'h3);
        pulse(4'b0010);
        rd_reg(4'd2, r);
        check_eq("ts_entry", r, 32'h0003_0002);
        rd_reg(4'd2, r);
        check_eq("empty_read", r, 32'h0);

        pulse(4'b0101);
        rd_reg(4'd1, r);
        check_eq("status_one", r, 32'h001);
        rd_reg(4'd2, r);
        check_eq("mask_merge", r & 32'hF, 32'h5);

        for (int i = 0; i <= DEPTH; i++) pulse(4'((i % 15) + 1));
        rd_reg(4'd1, r);
        check_eq("status_full_ovf", r, 32'hC10);
        wr_reg(4'd3, 32'h2);
        rd_reg(4'd1, r);
        check_eq("ovf_cleared", r, 32'h410);

        bus_cycle("full_push_pop", 4'b1000, 1'b1, 1'b0, 4'd2, 32'h0, r);
        rd_reg(4'd1, r);
        check_eq("full_push_pop_count", r, 32'h410);
        for (int i = 0; i < DEPTH; i++) rd_reg(4'd2, r);
        rd_reg(4'd1, r);
        check_eq("drained", r, 32'h200);

        rd_reg(4'd7, r);
        wr_reg(4'd5, 32'hFFFF_FFFF);
        rd_reg(4'd3, r);
        check_eq("ctrl_untouched", r, 32'h0);

        wr_reg(4'd3, 32'h1);
        check_eq("irq_empty", {31'b0, ins_irq}, 32'h0);
        pulse(4'b0001);
        idle();
        check_eq("irq_rise", {31'b0, ins_irq}, 32'h1);
        rd_reg(4'd2, r);
        idle();
        check_eq("irq_fall", {31'b0, ins_irq}, 32'h0);

        for (int i = 0; i < DEPTH; i++) pulse(4'b0110);
        bus_cycle("flush_push", 4'b0100, 1'b0, 1'b1, 4'd3, 32'h5, r);
        rd_reg(4'd1, r);
        check_eq("flush_status", r, 32'h200);
        idle();
        check_eq("flush_irq", {31'b0, ins_irq}, 32'h0);

        for (int i = 0; i < DEPTH; i++) pulse(4'b1001);
        bus_cycle("ovf_set_vs_clr", 4'b0001, 1'b0, 1'b1, 4'd3, 32'h3, r);
        rd_reg(4'd1, r);
        check_eq("ovf_set_wins", r, 32'hC10);

        @(negedge csi_clk);
        rsi_reset_n = 1'b0;
        sb.delete();
        ovf_m    = 1'b0;
        irq_en_m = 1'b0;
        #2;
        check_eq("irq_midreset", {31'b0, ins_irq}, 32'h0);
        @(negedge csi_clk);
        rsi_reset_n = 1'b1;
        rd_reg(4'd1, r);
        check_eq("status_midreset", r, 32'h200);
        rd_reg(4'd3, r);
        check_eq("ctrl_midreset", r, 32'h0);
        rd_reg(4'd2, r);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/key_event_queue.md
Name: key_event_queue

Overview:
- Sits directly downstream of the four key debouncers and receives their one-cycle short-press pulses.
- Timestamps each press and queues it in a FIFO, so the CPU loses no presses and sees their order.
- Exposes the queue over an Avalon-MM slave and raises an interrupt while events are pending.
- Replaces per-key sticky flags for software that polls slowly.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256.
- PRESCALE, 50000, csi_clk cycles per timestamp increment (1 ms at 50 MHz).
- TS_W, 16, timestamp width; fixed to 16 in this revision.

Ports:
- csi_clk  in  1  system clock
- rsi_reset_n  in  1  asynchronous active-low reset
- avs_s0_write  in  1  Avalon write strobe
- avs_s0_read  in  1  Avalon read strobe
- avs_s0_address  in  4  register word address
- avs_s0_writedata  in  32  write data
- avs_s0_readdata  out  32  read data, combinational, zero wait states
- key_pulse  in  4  one-cycle press pulses; bit n is key n
- ins_irq  out  1  level interrupt

Behaviour:
- Clock and reset:
  - One clock, csi_clk.
  - rsi_reset_n is asynchronous and active-low.
  - Reset clears pointers, count, overflow, irq_en, prescaler and timestamp.
  - After reset: ins_irq = 0 and avs_s0_readdata = 0.
- Timestamp:
  - The prescaler counts 0..PRESCALE-1.
  - On its terminal count, ts increments and wraps from 0xFFFF to 0.
- Push:
  - Any key_pulse bit high in cycle T queues one entry, entry = {ts, 12'b0, key_pulse}.
  - Simultaneous keys share one entry.
  - The entry is visible in STATUS and DATA at T+1.
- Register map (readdata is 0 when avs_s0_read = 0):
  - 0 ID, RO: reads 65.
  - 1 STATUS, RO: [8:0] count, [9] empty, [10] full, [11] overflow (sticky).
  - 2 DATA, RO: reads the head entry; an accepted read pops one entry. Reading while empty returns 0 and changes nothing.
  - 3 CTRL, RW: [0] irq_en, read back. Write [1]=1 clears overflow; write [2]=1 flushes. Bits [1] and [2] are self-clearing and read 0.
  - 4 TIME, RO: current ts in [15:0].
  - Other addresses: read 0, writes ignored.
- Full and overflow:
  - A push while full, with no pop in the same cycle, is dropped, sets overflow, and leaves contents intact.
- Simultaneous events:
  - Push and pop in the same cycle: count is unchanged, both are accepted, including when full or holding 1 entry.
  - Flush and push in the same cycle: flush wins, the event is discarded, overflow is not set.
  - Overflow clear and a new overflow in the same cycle: the set wins.
- Interrupt:
  - ins_irq = irq_en & ~empty, registered, so it asserts 1 cycle after its cause.
- Reset mid-operation: all queued entries are lost immediately.

Decomposition:
- Shared package:
  - register address constants
  - ID value 65
  - STATUS and CTRL bit positions
  - entry field offsets
- One sub-module, key_event_fifo: storage, wrapping pointers, count, and full/empty, with push, pop and flush inputs.
- Prescaler, timestamp, register decode and IRQ live in the top.

Test Plan:
- Reset, then read addr 0, addr 1 and ins_irq → readdata 65; STATUS 0x200 (empty); ins_irq 0.
- PRESCALE=4; pulse key_pulse=4'b0010 after 3 ticks; read addr 2 → 0x00030002; a second read of addr 2 → 0.
- Pulse 4'b0101 in a single cycle → one entry with mask 0x5; STATUS count = 1.
- Push DEPTH+1 events (16 + 1) → STATUS 0xC10 (full, overflow, count 16); entries read back in order.
- Write CTRL 0x2 → overflow bit reads 0.
- Full FIFO, pulse and DATA read in the same cycle → count stays 16; the newest entry lands at the tail and the oldest is returned.
- Write CTRL 0x1 with FIFO empty, then push → ins_irq rises 1 cycle after the push and falls 1 cycle after the final pop.
- Write CTRL 0x4 concurrently with a pulse → count 0, overflow 0, ins_irq 0.
